// File: rtl/game_hex_fx.sv
// Display-effects stage between the HEX segment PIO and the physical pins.
// Adds per-digit blinking and a software-triggered N-pulse flash burst, controlled over Avalon-MM.
module game_hex_fx #(
  parameter int DIGITS         = 4,
  parameter int CNT_W          = 26,
  parameter int DEFAULT_PERIOD = 25000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DIGITS*7-1:0]   seg_in,
  output logic [DIGITS*7-1:0]   hex_out,
  output logic                  fx_done
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_FLASH_OFF = 2'd1;
  localparam logic [1:0] ST_FLASH_ON  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    period;
  logic                phase;
  logic [7:0]          remaining;
  logic                done;
  logic                blink_en;
  logic [DIGITS-1:0]   blink_mask;

  logic                wr_en;
  logic                ctrl_wr;
  logic                period_wr;
  logic                flash_start;
  logic                status_wr;
  logic                busy;
  logic                run;
  logic                tick;
  logic                burst_end;
  logic [DIGITS*7-1:0] idle_pattern;
  logic                unused_wd;

  assign wr_en       = chipselect && !write_n;
  assign ctrl_wr     = wr_en && (address == 2'd0);
  assign period_wr   = wr_en && (address == 2'd1);
  assign flash_start = wr_en && (address == 2'd2) && (writedata[7:0] != 8'd0);
  assign status_wr   = wr_en && (address == 2'd3);

  assign busy    = (state != ST_IDLE);
  assign fx_done = done;

  // The prescaler only runs while something consumes its ticks: a burst, or enabled blinking.
  assign run  = busy || blink_en;
  assign tick = run && (cnt == period - CNT_ONE);

  // A FLASH restart or PERIOD write in the same cycle preempts the final tick of a burst.
  assign burst_end = (state == ST_FLASH_ON) && tick && (remaining == 8'd1)
                     && !flash_start && !period_wr;

  assign unused_wd = ^writedata[31:CNT_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_en   <= 1'b0;
      blink_mask <= '0;
      period     <= CNT_W'(DEFAULT_PERIOD);
    end else begin
      // NOTE: sequential state is always updated with <= so every register samples pre-edge values.
      if (ctrl_wr) begin
        blink_en   <= writedata[0];
        blink_mask <= writedata[4 +: DIGITS];
      end
      if (period_wr)
        period <= (writedata[CNT_W-1:0] == '0) ? CNT_ONE : writedata[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      phase     <= 1'b1;
      remaining <= 8'd0;
    end else if (flash_start) begin
      state     <= ST_FLASH_OFF;
      remaining <= writedata[7:0];
      cnt       <= '0;
    end else if (period_wr) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else begin
      cnt <= (!run || tick) ? '0 : cnt + CNT_ONE;
      case (state)
        ST_IDLE: begin
          if (!blink_en)
            phase <= 1'b1;
          else if (tick)
            phase <= ~phase;
        end
        ST_FLASH_OFF: begin
          if (tick)
            state <= ST_FLASH_ON;
        end
        ST_FLASH_ON: begin
          if (tick) begin
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              state <= ST_IDLE;
              phase <= 1'b1;
            end else begin
              state <= ST_FLASH_OFF;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Completion sets done even when software clears it in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      done <= 1'b0;
    else if (burst_end)
      done <= 1'b1;
    else if (status_wr && writedata[1])
      done <= 1'b0;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the block leaves a latch behind.
    idle_pattern = seg_in;
    for (int i = 0; i < DIGITS; i++) begin
      if (blink_en && blink_mask[i] && !phase)
        idle_pattern[7*i +: 7] = 7'h7F;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      hex_out <= '1;
    else begin
      case (state)
        ST_FLASH_OFF: hex_out <= '1;
        ST_FLASH_ON:  hex_out <= seg_in;
        default:      hex_out <= idle_pattern;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: begin
        readdata[0]             = blink_en;
        readdata[4 +: DIGITS]   = blink_mask;
      end
      2'd1:    readdata[CNT_W-1:0] = period;
      2'd2:    readdata[7:0]       = remaining;
      default: readdata[1:0]       = {done, busy};
    endcase
  end

endmodule

// File: tb/tb_game_hex_fx.sv
// Self-checking bench for game_hex_fx: directed steps then random bus traffic,
// compared each cycle against a timeline model of blink half-periods and flash bursts.
module tb_game_hex_fx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [27:0] seg_in = 28'd0;
  logic [27:0] hex_out;
  logic        fx_done;

  game_hex_fx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .seg_in     (seg_in),
    .hex_out    (hex_out),
    .fx_done    (fx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: edge counter plus the edges at which the blink half-period and the burst timeline began.
  int       cyc;
  int       m_period;
  logic     m_blink_en;
  logic [3:0] m_mask;
  logic     m_done;
  int       r_edge;
  logic     b_active;
  int       b_start;
  int       b_n;
  int       b_p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc        = 0;
    m_period   = 25000000;
    m_blink_en = 1'b0;
    m_mask     = 4'd0;
    m_done     = 1'b0;
    r_edge     = 0;
    b_active   = 1'b0;
    b_start    = 0;
    b_n        = 0;
    b_p        = 1;
  endtask

  function automatic int burst_len();
    return 2 * b_n * b_p;
  endfunction

  function automatic logic [27:0] exp_hex(input logic [27:0] seg);
    logic [27:0] e;
    int          j;
    logic        visible;
    e = seg;
    if (b_active) begin
      j = cyc - b_start;
      if (((j / b_p) % 2) == 0) e = '1;
    end else if (m_blink_en) begin
      j = cyc - r_edge;
      visible = (((j / m_period) % 2) == 0);
      for (int i = 0; i < 4; i++)
        if (m_mask[i] && !visible) e[7*i +: 7] = 7'h7F;
    end
    return e;
  endfunction

  function automatic int exp_remaining();
    if (!b_active) return 0;
    return b_n - ((cyc - b_start) / b_p) / 2;
  endfunction

  function automatic logic [31:0] exp_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {24'd0, m_mask, 3'd0, m_blink_en};
      2'd1:    return 32'(m_period);
      2'd2:    return 32'(exp_remaining());
      default: return {30'd0, m_done, b_active};
    endcase
  endfunction

  task automatic model_edge();
    if (chipselect && !write_n) begin
      case (address)
        2'd0: begin
          if (!m_blink_en) r_edge = cyc;
          m_blink_en = writedata[0];
          m_mask     = writedata[7:4];
        end
        2'd1: begin
          m_period = (writedata[25:0] == 26'd0) ? 1 : int'(writedata[25:0]);
          r_edge   = cyc;
        end
        2'd2: begin
          if (writedata[7:0] != 8'd0) begin
            b_active = 1'b1;
            b_start  = cyc;
            b_n      = int'(writedata[7:0]);
            b_p      = m_period;
          end
        end
        default: if (writedata[1]) m_done = 1'b0;
      endcase
    end
    if (b_active && cyc == b_start + burst_len()) begin
      b_active = 1'b0;
      m_done   = 1'b1;
      r_edge   = cyc;
    end
  endtask

  task automatic cycle();
    logic [27:0] e;
    e = exp_hex(seg_in);
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check("hex_out", hex_out, e);
    check("fx_done", fx_done, m_done);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cycle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_model(input logic [1:0] a, input string tag);
    address    = a;
    chipselect = 1'b1;
    #1;
    check(tag, readdata, exp_reg(a));
    chipselect = 1'b0;
  endtask

  task automatic rd_const(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address    = a;
    chipselect = 1'b1;
    #1;
    check(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic finish_burst();
    for (int i = 0; i < 400 && b_active; i++) cycle();
  endtask

  initial begin
    model_reset();

    // Reset and pass-through
    seg_in = 28'h0123456;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("hex_in_reset", hex_out, 28'hFFFFFFF);
    check("fx_done_in_reset", fx_done, 1'b0);
    rd_const(2'd1, 32'd25000000, "period_reset");
    rd_const(2'd3, 32'd0, "status_reset");
    #2 reset_n = 1'b1;
    model_reset();
    cycle();
    check("passthru_first", hex_out, 28'h0123456);
    rd_const(2'd0, 32'd0, "ctrl_reset");

    // Blink digit 1 with a 4-clock half-period
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h21);
    idle(17);
    wr(2'd0, 32'h0);
    idle(2);
    check("blink_restored", hex_out, 28'h0123456);

    // Flash burst of 2 pulses, 3-clock half-period
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd2);
    rd_const(2'd3, 32'd1, "flash_busy");
    rd_const(2'd2, 32'd2, "flash_rem");
    idle(11);
    rd_const(2'd3, 32'd1, "busy_before_end");
    cycle();
    rd_const(2'd3, 32'd2, "done_at_end");
    rd_const(2'd2, 32'd0, "rem_after_burst");
    check("fx_done_set", fx_done, 1'b1);

    // Completion coinciding with a done-clear: done stays set
    wr(2'd2, 32'd1);
    idle(5);
    wr(2'd3, 32'd2);
    rd_const(2'd3, 32'd2, "set_wins");
    wr(2'd3, 32'd2);
    rd_const(2'd3, 32'd0, "done_cleared");
    check("fx_done_clear", fx_done, 1'b0);

    // Restart mid-burst with one pulse
    seg_in = 28'h8ABCDEF;
    wr(2'd2, 32'd3);
    idle(2);
    rd_const(2'd2, 32'd3, "rem_before_restart");
    wr(2'd2, 32'd1);
    rd_const(2'd2, 32'd1, "rem_after_restart");
    idle(5);
    rd_const(2'd3, 32'd1, "restart_busy");
    cycle();
    rd_const(2'd3, 32'd2, "restart_done");

    // FLASH = 0 while idle is ignored
    wr(2'd2, 32'd0);
    rd_const(2'd3, 32'd2, "flash0_ignored");
    rd_const(2'd2, 32'd0, "flash0_rem");

    // PERIOD = 0 stored as 1; blink toggles every clock
    wr(2'd1, 32'd0);
    rd_const(2'd1, 32'd1, "period_zero");
    wr(2'd0, 32'h11);
    idle(8);

    // Asynchronous reset during FLASH_OFF
    wr(2'd0, 32'h0);
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd2);
    cycle();
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_hex", hex_out, 28'hFFFFFFF);
    check("async_reset_done", fx_done, 1'b0);
    rd_const(2'd3, 32'd0, "async_reset_status");
    rd_const(2'd1, 32'd25000000, "async_reset_period");
    @(posedge clk);
    #3 reset_n = 1'b1;
    model_reset();
    seg_in = 28'h5A5A5A5;
    idle(3);
    check("post_reset_passthru", hex_out, 28'h5A5A5A5);

    // Random traffic against the model
    for (int it = 0; it < 1500; it++) begin
      case ($urandom_range(0, 9))
        0: wr(2'd0, $urandom());
        1: if (b_active) cycle(); else wr(2'd1, 32'($urandom_range(0, 5)));
        2: begin
          if (b_active && b_start + burst_len() == cyc + 1) cycle();
          else wr(2'd2, 32'($urandom_range(0, 3)));
        end
        3: wr(2'd3, $urandom());
        4: begin
          rd_model(2'($urandom_range(0, 3)), "rand_read");
          cycle();
        end
        5: begin
          seg_in = 28'($urandom());
          cycle();
        end
        default: cycle();
      endcase
    end
    finish_burst();
    rd_model(2'd3, "final_status");
    rd_model(2'd0, "final_ctrl");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/game_hex_fx.md
Name: game_hex_fx

Overview:
- Display-effects stage directly downstream of the game's 28-bit HEX segment PIO.
- Takes the PIO's 4-digit x 7-segment active-low pattern and drives the physical HEX pins through a registered path.
- Applies per-digit blinking and a software-triggered N-pulse flash burst for game events such as a score or a loss.
- Controlled by software through its own 4-word Avalon-MM slave.

Parameters:
- DIGITS, 4, number of 7-segment digits; seg_in and hex_out are DIGITS*7 bits wide.
- CNT_W, 26, width of the half-period prescaler counter.
- DEFAULT_PERIOD, 25000000, reset value of the PERIOD register (0.5 s at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  Avalon register select.
- chipselect  in  1  Avalon chip select.
- write_n  in  1  Avalon write strobe, active low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; combinational, zero wait states.
- seg_in  in  28  segment pattern from the HEX PIO; digit i = seg_in[7i+6:7i]; active low.
- hex_out  out  28  segment pattern to the HEX pins; same packing and polarity as seg_in.
- fx_done  out  1  level; copy of STATUS.done.

Behaviour:
- Write condition: chipselect && !write_n. Reads decode the same address map combinationally; unused readdata bits read 0.
- Reg 0 CTRL (rw):
  - bit0 = blink_en.
  - bits[7:4] = blink_mask, one bit per digit; bit 4 maps to digit 0.
  - Reset value 0.
- Reg 1 PERIOD (rw):
  - Half-period in clocks, CNT_W bits; reset value DEFAULT_PERIOD.
  - A written value of 0 is stored as 1.
  - Any write clears the prescaler to 0 and sets phase = 1.
- Reg 2 FLASH:
  - Write: bits[7:0] = N. If N != 0, starts a burst; if N == 0, the write is ignored.
  - Read: remaining pulse count.
- Reg 3 STATUS:
  - bit0 = busy (read-only).
  - bit1 = done, sticky; writing 1 to bit1 clears it.
- Prescaler cnt counts 0..PERIOD-1. At PERIOD-1 it wraps to 0 and asserts tick for one cycle.
- State machine:
  - IDLE:
    - blink_en = 1: cnt runs; each tick toggles phase.
    - blink_en = 0: cnt is held at 0 and phase = 1.
  - A FLASH write with N != 0 from any state:
    - remaining <= N, cnt <= 0, busy <= 1; next state FLASH_OFF.
    - A FLASH write while busy restarts the burst with the new N.
  - FLASH_OFF: all digits blank. On tick -> FLASH_ON.
  - FLASH_ON: seg_in passes through unmasked.
    - On tick: remaining decrements.
    - If the old remaining was 1: go to IDLE, busy <= 0, done <= 1, phase <= 1, cnt <= 0.
    - Otherwise -> FLASH_OFF.
  - A burst runs regardless of blink_en and blink_mask.
- Output, registered, 1-cycle latency from seg_in:
  - IDLE: digit i = 7'h7F if (blink_en && blink_mask[i] && phase == 0), else seg_in digit i.
  - FLASH_OFF: all digits 7'h7F.
  - FLASH_ON: hex_out = seg_in.
- Simultaneous events:
  - FLASH start and done-clear in the same cycle cannot occur (different addresses).
  - Burst completion in the same cycle as a STATUS write of 1: done ends at 1; set wins.
  - A PERIOD write during a burst resets cnt, lengthening the current half-period; the state is unchanged.
- Reset values, asynchronous, including reset asserted mid-burst:
  - State IDLE; cnt 0; phase 1; remaining 0.
  - busy 0; done 0; fx_done 0.
  - hex_out 28'hFFFFFFF (all blank); CTRL 0; PERIOD DEFAULT_PERIOD.

Test Plan:
- Reset pass-through: release reset; seg_in = 28'h0123456.
  -> hex_out = 28'hFFFFFFF during reset, then 28'h0123456 one cycle after the first clock.
  -> readdata at addr 1 = 25000000.
- Blink: write PERIOD = 4, CTRL = 0x21 (blink digit 1).
  -> Digit 1 alternates visible / 7'h7F every 4 clocks.
  -> Digits 0, 2 and 3 stay unchanged.
  -> Writing CTRL = 0 restores digit 1 within 2 cycles.
- Flash burst: PERIOD = 3; write FLASH = 2.
  -> busy = 1; hex_out sequence is blank 3, on 3, blank 3, on 3 clocks.
  -> Then busy = 0, done = 1, fx_done = 1; FLASH read = 0.
  -> Writing STATUS = 2 clears fx_done.
- Restart and zero:
  - Mid-burst with remaining = 3, write FLASH = 1 -> exactly one more off/on pulse.
  - Write FLASH = 0 while idle -> no change; busy stays 0.
- PERIOD zero: write PERIOD = 0 -> reads back 1; blinking toggles every clock.
- Reset mid-burst: assert reset_n = 0 during FLASH_OFF.
  -> hex_out = 28'hFFFFFFF immediately (asynchronous); busy = 0, done = 0.
  -> After release: IDLE pass-through.
